// File: rtl/wb_daq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wb_daq_pkg
// Desc     : Shared types and constants for the DAQ Wishbone master sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package wb_daq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACT  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_BASE_HI = 31;
    localparam int CTRL_BASE_LO = 16;

    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wb_daq_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wb_daq_rr_arbiter
// Desc     : Combinational round-robin pick starting after the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module wb_daq_rr_arbiter
    import wb_daq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     grant_idx,
    output logic              valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = IW'((int'(last_grant) + i) % NUM_CH);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                grant_idx = cand;
                grant     = NUM_CH'(1) << cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_daq_master_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wb_daq_master_sequencer
// Desc     : Round-robin sharing of the DAQ Wishbone master with ring addressing.
// Revision : 1.0 - initial release
// ============================================================================
module wb_daq_master_sequencer
    import wb_daq_pkg::*;
#(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int NUM_CH      = 4,
    parameter int BUF_WORDS   = 256,
    parameter int ACT_TIMEOUT = 15
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [dw-1:0]        control_reg,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*dw-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic                 start,
    output logic [aw-1:0]        address,
    output logic [3:0]           selection,
    output logic                 write,
    output logic [dw-1:0]        data_wr,
    input  logic                 active,
    output logic [NUM_CH-1:0]    wrap_flag,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int IW    = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(BUF_WORDS);
    localparam int TW    = $clog2(ACT_TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [NUM_CH-1:0]   arb_grant, grant_oh;
    logic [IW-1:0]       arb_idx, grant_idx, last_grant;
    logic                arb_valid;
    logic [PTR_W-1:0]    wr_ptr [NUM_CH];
    logic [TW-1:0]       act_cnt;
    logic [aw-1:0]       base_addr, word_off, next_addr;
    logic [dw-1:0]       sel_data;
    logic                enable, clear, launch, act_to, done;
    logic                unused_ctrl;

    assign enable      = control_reg[CTRL_EN];
    assign clear       = control_reg[CTRL_CLR];
    assign unused_ctrl = &{1'b0, control_reg[CTRL_BASE_LO-1:CTRL_CLR+1]};

    // A channel still sees its ack in the first IDLE cycle; mask it so it is not re-granted.
    wb_daq_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
        .req        (ch_req & ~ch_ack),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    assign base_addr = aw'({control_reg[CTRL_BASE_HI:CTRL_BASE_LO], 16'h0000});
    assign word_off  = aw'(arb_idx) * aw'(BUF_WORDS) + aw'(wr_ptr[arb_idx]);
    assign next_addr = base_addr + (word_off << 2);
    assign sel_data  = ch_data[int'(arb_idx)*dw +: dw];

    assign launch = (state == ST_IDLE) && enable && !clear && arb_valid;
    assign act_to = (state == ST_WAIT_ACT) && !active && (act_cnt == TW'(ACT_TIMEOUT - 1));
    assign done   = (state == ST_WAIT_DONE) && !active;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (launch) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                start     = 1'b1;
                state_nxt = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (active)      state_nxt = ST_WAIT_DONE;
                else if (act_to) state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (!active) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            address     <= '0;
            selection   <= '0;
            write       <= 1'b0;
            data_wr     <= '0;
            ch_ack      <= '0;
            wrap_flag   <= '0;
            timeout_err <= 1'b0;
            grant_oh    <= '0;
            grant_idx   <= '0;
            last_grant  <= IW'(NUM_CH - 1);
            act_cnt     <= '0;
            for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
        end else begin
            ch_ack <= '0;
            if (launch) begin
                grant_oh  <= arb_grant;
                grant_idx <= arb_idx;
                address   <= next_addr;
                data_wr   <= sel_data;
                selection <= SEL_ALL;
                write     <= 1'b1;
            end
            if (state == ST_ISSUE)
                act_cnt <= '0;
            else if (state == ST_WAIT_ACT && !active)
                act_cnt <= act_cnt + 1'b1;
            // Timed-out grant is dropped silently; the pointer is untouched so it retries in place.
            if (act_to) begin
                timeout_err <= 1'b1;
                selection   <= '0;
                write       <= 1'b0;
            end
            if (done) begin
                ch_ack            <= grant_oh;
                wr_ptr[grant_idx] <= wr_ptr[grant_idx] + 1'b1;
                if (wr_ptr[grant_idx] == PTR_W'(BUF_WORDS - 1))
                    wrap_flag[grant_idx] <= 1'b1;
                last_grant <= grant_idx;
                selection  <= '0;
                write      <= 1'b0;
            end
            if (state == ST_IDLE && clear) begin
                wrap_flag   <= '0;
                timeout_err <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_daq_master_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_wb_daq_master_sequencer
// Desc     : Directed self-checking bench for the DAQ master sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_daq_master_sequencer;

    logic         wb_clk;
    logic         wb_rst;
    logic [31:0]  control_reg;
    logic [3:0]   ch_req;
    logic [127:0] ch_data;
    logic [3:0]   ch_ack;
    logic         start;
    logic [31:0]  address;
    logic [3:0]   selection;
    logic         write;
    logic [31:0]  data_wr;
    logic         active;
    logic [3:0]   wrap_flag;
    logic         timeout_err;
    logic         busy;

    int total = 0;
    int bad   = 0;

    wb_daq_master_sequencer #(
        .dw(32), .aw(32), .NUM_CH(4), .BUF_WORDS(256), .ACT_TIMEOUT(15)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .control_reg (control_reg),
        .ch_req      (ch_req),
        .ch_data     (ch_data),
        .ch_ack      (ch_ack),
        .start       (start),
        .address     (address),
        .selection   (selection),
        .write       (write),
        .data_wr     (data_wr),
        .active      (active),
        .wrap_flag   (wrap_flag),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", start, 1);
    endtask

    // Drive one transaction: active high for k cycles after the start pulse.
    task automatic serve(input int k, output logic [31:0] a, output logic [31:0] d,
                         output logic [3:0] ack);
        int n = 0;
        wait_start();
        a = address;
        d = data_wr;
        chk("sel_issue", selection, 4'hF);
        chk("we_issue", write, 1);
        tick();
        chk("start_one_cycle", start, 0);
        active = 1'b1;
        repeat (k) tick();
        active = 1'b0;
        while (ch_ack === 4'b0 && n < 5) begin
            tick();
            n++;
        end
        ack = ch_ack;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  ack;
        int          s;

        wb_rst      = 1'b0;
        control_reg = 32'h0001_0001;
        ch_req      = 4'b0;
        ch_data     = '0;
        active      = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_addr", address, 0);
        chk("rst_sel", selection, 0);
        chk("rst_ack", ch_ack, 0);
        chk("rst_wrap", wrap_flag, 0);
        chk("rst_tmo", timeout_err, 0);
        wb_rst = 1'b1;
        tick();

        // Single ch2 write, active held two cycles
        ch_data[95:64] = 32'hDEAD_BEEF;
        ch_req = 4'b0100;
        serve(2, a, d, ack);
        chk("t1_addr", a, 32'h0001_0800);
        chk("t1_data", d, 32'hDEAD_BEEF);
        chk("t1_ack", ack, 4'b0100);
        ch_req = 4'b0;
        tick();
        chk("t1_ack_pulse", ch_ack, 0);
        chk("t1_sel_idle", selection, 0);
        chk("t1_we_idle", write, 0);
        chk("t1_busy_idle", busy, 0);

        // Reset hit while in WAIT_DONE; second ch2 write proves wr_ptr[2]=1
        ch_req = 4'b0100;
        wait_start();
        chk("t6_addr", address, 32'h0001_0804);
        tick();
        active = 1'b1;
        tick();
        chk("t6_busy", busy, 1);
        wb_rst = 1'b0;
        #1;
        chk("t6_start", start, 0);
        chk("t6_addr0", address, 0);
        chk("t6_sel0", selection, 0);
        chk("t6_we0", write, 0);
        chk("t6_data0", data_wr, 0);
        chk("t6_ack0", ch_ack, 0);
        chk("t6_busy0", busy, 0);
        active = 1'b0;
        ch_req = 4'b0;
        tick();
        wb_rst = 1'b1;
        tick();

        // All four channels requesting: order 0,1,2,3,0
        for (int i = 0; i < 4; i++) ch_data[i*32 +: 32] = 32'hA000_0000 + i;
        ch_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            serve(1, a, d, ack);
            chk("t2_ack", ack, 4'b0001 << (i % 4));
            chk("t2_data", d, 32'hA000_0000 + (i % 4));
            chk("t2_addr", a, (i == 4) ? 32'h0001_0004 : 32'h0001_0000 + i * 32'h400);
        end
        ch_req = 4'b0;
        control_reg = 32'h0001_0003;
        tick();
        control_reg = 32'h0001_0001;
        chk("t3_clear_wrap", wrap_flag, 0);

        // 256 ch1 writes to wrap the ring
        ch_data[63:32] = 32'h1111_2222;
        ch_req = 4'b0010;
        for (int i = 0; i < 256; i++) begin
            serve(1, a, d, ack);
            chk("t3_addr", a, 32'h0001_0400 + i * 4);
            chk("t3_ack", ack, 4'b0010);
            if (i == 254) chk("t3_wrap_pre", wrap_flag, 0);
        end
        chk("t3_last_addr", a, 32'h0001_07FC);
        chk("t3_wrap_set", wrap_flag, 4'b0010);
        serve(1, a, d, ack);
        chk("t3_wrapped_addr", a, 32'h0001_0400);
        ch_req = 4'b0;
        control_reg = 32'h0001_0003;
        tick();
        control_reg = 32'h0001_0001;
        chk("t3_wrap_cleared", wrap_flag, 0);
        ch_req = 4'b0010;
        serve(1, a, d, ack);
        chk("t3_after_clear", a, 32'h0001_0400);
        ch_req = 4'b0;
        tick();

        // Timeout: active never rises
        ch_data[127:96] = 32'h3333_4444;
        ch_req = 4'b1000;
        wait_start();
        chk("t4_addr", address, 32'h0001_0C00);
        s = 0;
        repeat (14) begin
            tick();
            if (ch_ack !== 4'b0) s++;
        end
        chk("t4_tmo_early", timeout_err, 0);
        chk("t4_busy_wait", busy, 1);
        for (int n = 0; n < 20 && busy === 1'b1; n++) begin
            tick();
            if (ch_ack !== 4'b0) s++;
        end
        chk("t4_idle", busy, 0);
        chk("t4_tmo_set", timeout_err, 1);
        chk("t4_no_ack", s, 0);
        serve(1, a, d, ack);
        chk("t4_retry_addr", a, 32'h0001_0C00);
        chk("t4_retry_ack", ack, 4'b1000);
        ch_req = 4'b0;
        tick();

        // enable dropped in WAIT_DONE
        ch_data[31:0] = 32'h5555_0000;
        ch_req = 4'b0001;
        wait_start();
        chk("t5_addr", address, 32'h0001_0000);
        tick();
        active = 1'b1;
        tick();
        control_reg = 32'h0001_0000;
        ch_req = 4'b0011;
        active = 1'b0;
        tick();
        chk("t5_ack", ch_ack, 4'b0001);
        ch_req = 4'b0010;
        s = 0;
        repeat (8) begin
            tick();
            if (start === 1'b1) s++;
        end
        chk("t5_no_start", s, 0);
        chk("t5_idle", busy, 0);
        control_reg = 32'h0001_0001;
        serve(1, a, d, ack);
        chk("t5_resume_ack", ack, 4'b0010);
        chk("t5_resume_addr", a, 32'h0001_0404);
        ch_req = 4'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_daq_master_sequencer.md
Name: wb_daq_master_sequencer

Overview:
Round-robin scheduler that shares the DAQ Wishbone bus master between NUM_CH acquisition channels. It takes one-word write requests from each channel and computes a per-channel circular-buffer address in memory. It sequences the master interface's start/active handshake one transaction at a time. It sits between the channel sample logic and wb_master_interface inside the DAQ bus master, and drives that interface's start/address/selection/write/data_wr inputs.

Parameters:
dw, 32, data width
aw, 32, address width
NUM_CH, 4, number of requesting channels (2..8)
BUF_WORDS, 256, words per channel ring buffer (power of 2)
ACT_TIMEOUT, 15, max cycles from start to active rising

Ports:
wb_clk  in  1  clock, all logic on rising edge
wb_rst  in  1  asynchronous, active-low reset
control_reg  in  dw  bit0 enable, bit1 clear (level), [31:16] base address upper half
ch_req  in  NUM_CH  per-channel request; held until ch_ack
ch_data  in  NUM_CH*dw  channel i word at [i*dw +: dw], stable while ch_req[i]
ch_ack  out  NUM_CH  one-cycle pulse when channel's write completes
start  out  1  one-cycle launch pulse to master interface
address  out  aw  byte address of current transaction
selection  out  4  byte selects, always 4'hF when issuing
write  out  1  always 1 when issuing
data_wr  out  dw  word being written
active  in  1  master interface busy; rises after start, falls on ack/err/rty
wrap_flag  out  NUM_CH  sticky; set when channel pointer wraps
timeout_err  out  1  sticky; active failed to rise within ACT_TIMEOUT
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (wb_rst=0, async): FSM=IDLE; start=0, address=0, selection=0, write=0, data_wr=0, ch_ack=0, wrap_flag=0, timeout_err=0, busy=0. All wr_ptr=0; last_grant=NUM_CH-1, so ch0 wins first.
- Ring addressing: address = {control_reg[31:16],16'h0} + ((ch*BUF_WORDS + wr_ptr[ch]) << 2). wr_ptr is log2(BUF_WORDS) bits. Sum is truncated to aw bits.
- Arbitration: round-robin. Search starts at last_grant+1 modulo NUM_CH; the first channel with ch_req=1 wins. Evaluated only in IDLE.
- FSM states:
  - IDLE: if enable=1 and clear=0 and any ch_req, latch grant, address and data_wr, set selection=4'hF and write=1, go to ISSUE. busy=0 only here.
  - ISSUE: start=1 for exactly one cycle, then go to WAIT_ACT; clear the timeout counter.
  - WAIT_ACT: when active=1, go to WAIT_DONE. If the counter reaches ACT_TIMEOUT, set timeout_err, drop the grant without ch_ack, leave wr_ptr unchanged, and go to IDLE.
  - WAIT_DONE: when active=0, pulse ch_ack[grant] for one cycle, increment wr_ptr[grant], and set last_grant=grant. If the old wr_ptr was BUF_WORDS-1, it wraps to 0 and wrap_flag[grant] is set. Go to IDLE.
- Latency: best case 4 cycles from ch_req to ch_ack (IDLE→ISSUE→WAIT_ACT→WAIT_DONE plus 1-cycle active). At most one transaction in flight.
- address, selection, write and data_wr stay stable from ISSUE until return to IDLE. On return to IDLE, selection and write go to 0.
- enable=0 mid-transaction: the in-flight transaction completes normally. No new grant is made.
- clear=1: wr_ptr, wrap_flag and timeout_err are cleared synchronously. This is honoured only in IDLE; outside IDLE it is deferred until IDLE. No grants are made while clear=1.
- ch_req dropped before its grant: ignored, no ack. ch_req dropped after its grant: the transaction still completes and ch_ack still pulses.
- Simultaneous requests on all channels: serviced in order ch0, ch1, …, ch(NUM_CH-1), ch0, …
- data_rd is not used; the block only writes.

Decomposition:
- Package wb_daq_pkg holds:
  - FSM state encoding (IDLE/ISSUE/WAIT_ACT/WAIT_DONE, 2 bits)
  - control_reg bit indices (CTRL_EN=0, CTRL_CLR=1, CTRL_BASE_HI=31, CTRL_BASE_LO=16)
  - SEL_ALL=4'hF
- One sub-module: wb_daq_rr_arbiter (combinational round-robin pick from req vector and last_grant; outputs one-hot grant and index).

Test Plan:
- Single request, BUF_WORDS=256, base 0x0001: ch2 req, data 0xDEADBEEF; active high for 2 cycles → address=0x0001_0800, data_wr=0xDEADBEEF, sel=F, we=1, one start pulse, ch_ack[2] pulses once, wr_ptr[2]=1.
- All four channels requesting continuously → grants in order 0,1,2,3,0. Second ch0 transaction at address base+0x004.
- Wrap: 256 consecutive ch1 writes → 256th at base+0x7FC, wrap_flag[1]=1, next write at base+0x400. clear=1 in IDLE → wrap_flag=0, next ch1 write at base+0x400.
- Timeout: active held 0 after start → timeout_err=1 after 15 cycles, no ch_ack, FSM back in IDLE, same request reissued at the same address.
- enable dropped during WAIT_DONE → current ch_ack still issued. No further start while enable=0.
- Reset asserted in WAIT_DONE → all outputs 0 immediately (async), FSM IDLE, pointers 0.
